// File: rtl/alu64_sequencer.sv
// alu64_sequencer
//   Runs 64-bit data operations on an external 32-bit ALU in two passes.
//   The low word goes first, then the high word, with the carry chained
//   between the passes. The block accepts one request at a time and returns
//   a 64-bit result plus {N,Z,V,C} flags.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_op, req_a, req_b   operation select and 64-bit operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_result, rsp_flags  64-bit result and {N,Z,V,C}
//   alu_in1/in2/c/cmd      drive to the 32-bit ALU (parked when not in use)
//   alu_result/alu_status  combinational return from the ALU
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request, ALU parked at IDLE_CMD with zero inputs
// LO    | ALU works on bits [31:0]; capture result, carry and zero
// HI    | ALU works on bits [63:32] with the chained carry; build flags
// DONE  | response valid and held until rsp_ready
//
// A request accepted at edge T is in DONE after edge T+2, so the consumer
// first samples rsp_valid=1 at edge T+3. The shortest repeat interval is
// therefore four cycles.

module alu64_sequencer #(
  parameter int         OP_W     = 3,
  parameter logic [3:0] IDLE_CMD = 4'b0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [63:0]     req_a,
  input  logic [63:0]     req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [63:0]     rsp_result,
  output logic [3:0]      rsp_flags,
  output logic [31:0]     alu_in1,
  output logic [31:0]     alu_in2,
  output logic            alu_c,
  output logic [3:0]      alu_cmd,
  input  logic [31:0]     alu_result,
  input  logic [3:0]      alu_status
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_RSB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ORR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_EOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(6);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [63:0]     a_q;
  logic [63:0]     b_q;
  logic            c_lo;
  logic            z_lo;

  logic [31:0]     a_w;
  logic [31:0]     b_w;
  logic            carry_w;

  assign req_ready = (state == S_IDLE);

  // Word select comes from the captured operands only, never from req_*.
  assign a_w = (state == S_HI) ? a_q[63:32] : a_q[31:0];
  assign b_w = (state == S_HI) ? b_q[63:32] : b_q[31:0];

  // Subtraction is a + ~b + 1. The +1 enters as the low-pass carry-in and
  // the high pass always takes the carry out of the low pass.
  assign carry_w = (state == S_HI) ? c_lo : (op_q != OP_ADD);

  always_comb begin
    alu_cmd = IDLE_CMD;
    alu_in1 = '0;
    alu_in2 = '0;
    alu_c   = 1'b0;
    if (state == S_LO || state == S_HI) begin
      case (op_q)
        OP_ADD: begin
          alu_cmd = CMD_ADC;
          alu_in1 = a_w;
          alu_in2 = b_w;
          alu_c   = carry_w;
        end
        OP_SUB: begin
          alu_cmd = CMD_ADC;
          alu_in1 = a_w;
          alu_in2 = ~b_w;
          alu_c   = carry_w;
        end
        OP_RSB: begin
          alu_cmd = CMD_ADC;
          alu_in1 = b_w;
          alu_in2 = ~a_w;
          alu_c   = carry_w;
        end
        OP_AND: begin
          alu_cmd = CMD_AND;
          alu_in1 = a_w;
          alu_in2 = b_w;
        end
        OP_ORR: begin
          alu_cmd = CMD_ORR;
          alu_in1 = a_w;
          alu_in2 = b_w;
        end
        OP_EOR: begin
          alu_cmd = CMD_EOR;
          alu_in1 = a_w;
          alu_in2 = b_w;
        end
        OP_MOV: begin
          alu_cmd = CMD_MOV;
          alu_in2 = b_w;
        end
        default: begin
          alu_cmd = CMD_MVN;
          alu_in1 = b_w;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_lo       <= 1'b0;
      z_lo       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            state <= S_LO;
          end
        end
        S_LO: begin
          rsp_result[31:0] <= alu_result;
          c_lo             <= alu_status[0];
          z_lo             <= alu_status[2];
          state            <= S_HI;
        end
        S_HI: begin
          rsp_result[63:32] <= alu_result;
          // The 64-bit result is zero only if both halves are zero.
          rsp_flags <= {alu_status[3], z_lo & alu_status[2],
                        alu_status[1], alu_status[0]};
          rsp_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu64_sequencer.sv
// tb_alu64_sequencer
//   Bench for alu64_sequencer. It contains a behavioural 32-bit ALU that
//   answers the DUT, plus a 64-bit reference model computed directly from
//   operation semantics (plain 64-bit arithmetic and compares). A
//   compare process checks handshakes, response data and ALU parking on
//   every cycle.

module tb_alu64_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_c;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [3:0]  alu_status;

  int checks   = 0;
  int failures = 0;

  alu64_sequencer #(.OP_W(3), .IDLE_CMD(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_c      (alu_c),
    .alu_cmd    (alu_cmd),
    .alu_result (alu_result),
    .alu_status (alu_status)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_status = '0;
    case (alu_cmd)
      4'b0011: begin
        alu_sum    = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_c};
        alu_result = alu_sum[31:0];
        alu_status = {alu_sum[31], alu_sum[31:0] == 32'd0,
                      (alu_in1[31] == alu_in2[31]) && (alu_sum[31] != alu_in1[31]),
                      alu_sum[32]};
      end
      4'b0110, 4'b0111, 4'b1000, 4'b0001, 4'b1001: begin
        case (alu_cmd)
          4'b0110: alu_result = alu_in1 & alu_in2;
          4'b0111: alu_result = alu_in1 | alu_in2;
          4'b1000: alu_result = alu_in1 ^ alu_in2;
          4'b0001: alu_result = alu_in2;
          default: alu_result = ~alu_in1;
        endcase
        alu_status = {alu_result[31], alu_result == 32'd0, 2'b00};
      end
      default: begin
        alu_result = '0;
        alu_status = '0;
      end
    endcase
  end

  // 64-bit reference: returns {result, N, Z, V, C}.
  function automatic logic [67:0] model(input logic [2:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic v;
    logic c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'd2: begin
        r = b - a;
        c = (b >= a);
        v = (a[63] != b[63]) && (r[63] != b[63]);
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = b;
      default: r = ~b;
    endcase
    return {r, r[63], r == 64'd0, v, c};
  endfunction

  task automatic check(input string name, input logic [67:0] act,
                       input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: a queue of expected responses and the
  // number of edges since the pending request was accepted.
  logic [67:0] exp_q[$];
  int          age     = 0;
  bit          started = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      age = 0;
    end else if (exp_q.size() != 0) begin
      if (age >= 2 && rsp_ready) void'(exp_q.pop_front());
      else if (age < 2) age++;
    end else if (req_valid) begin
      exp_q.push_back(model(req_op, req_a, req_b));
      age = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit pend;
      pend = (exp_q.size() != 0);
      check("req_ready", {67'd0, req_ready}, {67'd0, !pend});
      check("rsp_valid", {67'd0, rsp_valid}, {67'd0, pend && age >= 2});
      if (pend && age >= 2)
        check("rsp_data", {rsp_result, rsp_flags}, exp_q[0]);
      if (!pend)
        check("alu_park", {31'd0, alu_cmd, alu_in1, alu_in2, alu_c}, 68'd0);
    end
  end

  task automatic send(input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("send_ready_timeout", 68'd0, 68'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    // Scramble the request bus so any late dependence on req_* shows up.
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_a     = {$urandom(), $urandom()};
    req_b     = {$urandom(), $urandom()};
  endtask

  task automatic drain(input int hold);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 68'd0, 68'd1);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFFFFFF_FFFFFFFF;
      2: return 64'h7FFFFFFF_FFFFFFFF;
      3: return 64'h00000000_FFFFFFFF;
      4: return 64'h80000000_00000000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    started = 1;

    check("reset_state", {rsp_result, rsp_flags}, 68'd0);
    check("reset_valid", {66'd0, rsp_valid, req_ready}, 68'd1);

    // Hand-computed expectations that pin the model.
    check("pin_add_carry", model(3'd0, 64'h00000000_FFFFFFFF, 64'd1),
          {64'h00000001_00000000, 4'b0000});
    check("pin_sub_borrow", model(3'd1, 64'd0, 64'd1),
          {64'hFFFFFFFF_FFFFFFFF, 4'b1000});
    check("pin_sub_equal", model(3'd1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0),
          {64'd0, 4'b0101});
    check("pin_add_ovf", model(3'd0, 64'h7FFFFFFF_FFFFFFFF, 64'd1),
          {64'h80000000_00000000, 4'b1010});
    check("pin_rsb", model(3'd2, 64'd1, 64'd0),
          {64'hFFFFFFFF_FFFFFFFF, 4'b1000});
    check("pin_eor", model(3'd5, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001),
          {64'd0, 4'b0100});
    check("pin_mvn", model(3'd7, 64'd0, 64'd0),
          {64'hFFFFFFFF_FFFFFFFF, 4'b1000});

    // Directed cases; the compare process checks latency and data.
    send(3'd0, 64'h00000000_FFFFFFFF, 64'd1);
    check("lat_lo", {67'd0, rsp_valid}, 68'd0);
    @(negedge clk);
    check("lat_hi", {67'd0, rsp_valid}, 68'd0);
    @(negedge clk);
    check("lat_done", {rsp_result, rsp_flags}, {64'h00000001_00000000, 4'b0000});
    drain(0);
    send(3'd1, 64'd0, 64'd1);                                     drain(0);
    send(3'd1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0);     drain(1);
    send(3'd0, 64'h7FFFFFFF_FFFFFFFF, 64'd1);                     drain(0);
    send(3'd2, 64'd1, 64'd0);                                     drain(0);
    send(3'd7, 64'd0, 64'd0);                                     drain(0);

    // Backpressure with a competing request held on the bus.
    send(3'd5, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 64'd5;
    req_b     = 64'd6;
    repeat (5) begin
      check("bp_data", {rsp_result, rsp_flags}, {64'd0, 4'b0100});
      check("bp_ready", {66'd0, req_ready, rsp_valid}, 68'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release", {66'd0, req_ready, rsp_valid}, 68'd2);

    // Reset while in HI.
    send(3'd0, 64'h11111111_22222222, 64'h33333333_44444444);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_op", {rsp_result, 1'b0, rsp_valid, req_ready, alu_cmd == 4'd0},
          {64'd0, 4'b0011});
    rst = 1'b0;
    send(3'd0, 64'd1, 64'd1);
    drain(0);
    check("after_rst_add", {4'd0, rsp_result}, {4'd0, 64'd2});

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), rnd64(), rnd64());
      drain(int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
